fifo_36bit_drain: RTL and testbench
===================================

FIFO_36BIT_DRAIN -- requirements
Module: fifo_36bit_drain

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: fifo_rd_data  input  36  FIFO read word, combinational from FIFO (valid same cycle as fifo_empty=0).
REQ-004 SHALL have port: fifo_empty  input  1  FIFO empty flag.
REQ-005 SHALL have port: fifo_rd_en  output  1  FIFO pop; FIFO advances its read pointer on the edge where this is 1.
REQ-006 SHALL have port: out_data  output  35  stream payload = word[34:0].
REQ-007 SHALL have port: out_last  output  1  end-of-packet = word[35].
REQ-008 SHALL have port: out_valid  output  1  stream valid.
REQ-009 SHALL have port: out_ready  input  1  stream ready from consumer.
REQ-010 SHALL have port: flush  input  1  single-cycle request to discard the current packet.
REQ-011 SHALL have port: flush_busy  output  1  high while in FLUSH state.
REQ-012 SHALL have port: word_count  output  16  words delivered on stream (handshakes).
REQ-013 SHALL have port: pkt_count  output  16  packets delivered (handshakes with out_last=1).

Function
REQ-014 SHALL hold a 2-entry in-order output buffer (occupancy 0..2); out_valid = (occupancy != 0); out_data/out_last = head entry.
REQ-015 SHALL define pop = out_valid & out_ready; head removed on the edge where pop=1.
REQ-016 SHALL use states STREAM and FLUSH only; reset state STREAM.
REQ-017 In STREAM: fifo_rd_en = !fifo_empty & (occupancy < 2 | pop); never asserted when fifo_empty=1.
REQ-018 In STREAM: on edge with fifo_rd_en=1, fifo_rd_data SHALL be written to the buffer tail; word visible on out_* the next cycle if buffer was empty (latency 1 cycle from FIFO non-empty to out_valid).
REQ-019 Simultaneous push and pop SHALL keep occupancy unchanged with order preserved; with occupancy 2 and pop, one new word SHALL be accepted.
REQ-020 out_data/out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 flush=1 in STREAM SHALL, on that edge: clear the buffer (occupancy 0, no pop counted even if out_ready=1), suppress fifo_rd_en that cycle, enter FLUSH.
REQ-022 In FLUSH: fifo_rd_en = !fifo_empty; popped words discarded; out_valid=0; flush_busy=1.
REQ-023 In FLUSH: on pop of a word with bit35=1, SHALL return to STREAM on that edge; next word resumes normal buffering.
REQ-024 flush while in FLUSH SHALL be ignored; FLUSH with FIFO empty SHALL wait indefinitely.
REQ-025 word_count SHALL increment by 1 per pop; pkt_count by 1 per pop with out_last=1; both wrap 0xFFFF -> 0x0000; discarded words not counted.

Reset
REQ-026 rst=1 at a rising edge SHALL set: state STREAM, occupancy 0, out_valid=0, out_data=0, out_last=0, flush_busy=0, word_count=0, pkt_count=0; takes priority over all other inputs, including mid-FLUSH.
REQ-027 fifo_rd_en SHALL be 0 during any cycle with rst=1.

Verification
REQ-028 FIFO holds 0x0_0000_0001, 0x0_0000_0002, 0x8_0000_0003; out_ready=1 -> out_data 1,2,3 on consecutive cycles, out_last only on 3, word_count=3, pkt_count=1.
REQ-029 out_ready=0, FIFO holds 5 words -> exactly 2 fifo_rd_en pulses, then rd_en=0, out_data stable at word0; release out_ready -> all 5 in order, no duplicates or drops.
REQ-030 FIFO empty from reset -> fifo_rd_en never 1; push one word -> out_valid=1 exactly one cycle after fifo_empty falls.
REQ-031 Occupancy 2, flush=1 with out_ready=1, FIFO holds 0x0_..A, 0x8_..B, 0x0_..C -> buffer cleared, counts unchanged, A and B discarded, flush_busy high until B popped, C next on stream.
REQ-032 word_count preloaded to 0xFFFF by 65535 handshakes, one more -> word_count=0x0000.
REQ-033 rst=1 asserted during FLUSH with occupancy 0 and during STREAM with occupancy 2 -> next cycle all outputs at REQ-026 values, state STREAM.

Source files
------------

// File: rtl/fifo_36bit_drain_if.sv
// Bus bundle for fifo_36bit_drain: FIFO read side,
// output stream, flush control and delivery counters.
interface fifo_36bit_drain_if;
  logic [35:0] fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [34:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        flush_busy;
  logic [15:0] word_count;
  logic [15:0] pkt_count;

  modport master (
    input  fifo_rd_data,
    input  fifo_empty,
    input  out_ready,
    input  flush,
    output fifo_rd_en,
    output out_data,
    output out_last,
    output out_valid,
    output flush_busy,
    output word_count,
    output pkt_count
  );

  modport slave (
    output fifo_rd_data,
    output fifo_empty,
    output out_ready,
    output flush,
    input  fifo_rd_en,
    input  out_data,
    input  out_last,
    input  out_valid,
    input  flush_busy,
    input  word_count,
    input  pkt_count
  );
endinterface

// File: rtl/fifo_36bit_drain.sv
// Drains a show-ahead FIFO of 36-bit words into a valid/ready
// stream through a 2-entry buffer, with packet-discard flush.
module fifo_36bit_drain (
  input  logic                clk,
  input  logic                rst,
  fifo_36bit_drain_if.master  bus
);

  typedef enum logic {
    STREAM,
    FLUSH
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [35:0] ent0;
  logic [35:0] ent1;
  logic [1:0]  occ;
  logic [15:0] wc;
  logic [15:0] pc;

  logic        valid;
  logic        pop;
  logic        rd_en;
  logic        keep;
  logic        clear;
  logic        push;
  logic        take;

  assign valid = (occ != 2'd0);
  assign pop   = valid & bus.out_ready;
  assign push  = keep & rd_en;
  assign take  = keep & pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STREAM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    keep      = 1'b0;
    clear     = 1'b0;
    unique case (state)
      STREAM: begin
        if (bus.flush) begin
          clear     = 1'b1;
          state_nxt = FLUSH;
        end else begin
          keep  = 1'b1;
          rd_en = !bus.fifo_empty
                & ((occ != 2'd2) | pop);
        end
      end
      FLUSH: begin
        rd_en = !bus.fifo_empty;
        // End of the discarded packet: resume streaming
        if (rd_en && bus.fifo_rd_data[35]) begin
          state_nxt = STREAM;
        end
      end
      default: begin
        state_nxt = STREAM;
      end
    endcase
    if (rst) begin
      rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0 <= 36'd0;
      ent1 <= 36'd0;
      occ  <= 2'd0;
      wc   <= 16'd0;
      pc   <= 16'd0;
    end else if (clear) begin
      occ <= 2'd0;
    end else begin
      case ({take, push})
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= bus.fifo_rd_data;
          end else begin
            ent0 <= ent1;
            ent1 <= bus.fifo_rd_data;
          end
        end
        2'b10: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) begin
            ent0 <= bus.fifo_rd_data;
          end else begin
            ent1 <= bus.fifo_rd_data;
          end
          occ <= occ + 2'd1;
        end
        default: begin
        end
      endcase
      if (take) begin
        wc <= wc + 16'd1;
        if (ent0[35]) begin
          pc <= pc + 16'd1;
        end
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = valid;
  assign bus.out_data   = ent0[34:0];
  assign bus.out_last   = ent0[35];
  assign bus.flush_busy = (state == FLUSH);
  assign bus.word_count = wc;
  assign bus.pkt_count  = pc;

endmodule

// File: tb/tb_fifo_36bit_drain.sv
// Bench for fifo_36bit_drain: queue-based reference model,
// per-cycle compare, directed scenarios and random traffic.
module tb_fifo_36bit_drain;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_36bit_drain_if bus();

  fifo_36bit_drain dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [35:0] src_q[$];
  logic [35:0] mq[$];
  logic [35:0] got_q[$];
  bit          flushing;
  logic [15:0] mwc;
  logic [15:0] mpc;
  int          rd_pulses;
  int          busy_cnt;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    bus.fifo_empty = (src_q.size() == 0);
    bus.fifo_rd_data = (src_q.size() == 0) ? 36'h0 : src_q[0];
  endtask

  // One clock: compare before the edge, advance model at the edge
  task automatic cycle();
    logic [35:0] w;
    bit empty;
    bit e_valid;
    bit e_pop;
    bit e_rd;
    bit d_rd;
    bit d_pop;
    drive_src();
    empty = (src_q.size() == 0);
    #1;
    e_valid = (mq.size() != 0);
    e_pop = e_valid && bus.out_ready;
    if (rst) e_rd = 1'b0;
    else if (flushing) e_rd = !empty;
    else e_rd = !bus.flush && !empty && (mq.size() < 2 || e_pop);
    chk("fifo_rd_en", 64'(bus.fifo_rd_en), 64'(e_rd));
    chk("out_valid", 64'(bus.out_valid), 64'(e_valid));
    chk("flush_busy", 64'(bus.flush_busy), 64'(flushing));
    chk("word_count", 64'(bus.word_count), 64'(mwc));
    chk("pkt_count", 64'(bus.pkt_count), 64'(mpc));
    if (e_valid) begin
      chk("out_data", 64'(bus.out_data), 64'(mq[0][34:0]));
      chk("out_last", 64'(bus.out_last), 64'(mq[0][35]));
    end
    d_rd = bus.fifo_rd_en;
    d_pop = bus.out_valid && bus.out_ready;
    if (d_pop && !rst && !bus.flush)
      got_q.push_back({bus.out_last, bus.out_data});
    if (d_rd) rd_pulses++;
    if (bus.flush_busy) busy_cnt++;
    w = empty ? 36'h0 : src_q[0];
    @(posedge clk);
    if (d_rd && !empty) void'(src_q.pop_front());
    if (rst) begin
      mq.delete();
      flushing = 1'b0;
      mwc = 16'd0;
      mpc = 16'd0;
    end else if (!flushing && bus.flush) begin
      mq.delete();
      flushing = 1'b1;
    end else if (flushing) begin
      if (e_rd && w[35]) flushing = 1'b0;
    end else begin
      if (e_pop) begin
        mwc = mwc + 16'd1;
        if (mq[0][35]) mpc = mpc + 16'd1;
        void'(mq.pop_front());
      end
      if (e_rd) mq.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    src_q.delete();
    rst = 1'b1;
    bus.flush = 1'b0;
    cycle();
    rst = 1'b0;
    got_q.delete();
    rd_pulses = 0;
    busy_cnt = 0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'h0);
    chk({tag, "_data"}, 64'(bus.out_data), 64'h0);
    chk({tag, "_last"}, 64'(bus.out_last), 64'h0);
    chk({tag, "_busy"}, 64'(bus.flush_busy), 64'h0);
    chk({tag, "_wc"}, 64'(bus.word_count), 64'h0);
    chk({tag, "_pc"}, 64'(bus.pkt_count), 64'h0);
  endtask

  function automatic logic [35:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return {($urandom_range(0, 3) == 0), t[34:0]};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [35:0] exp5[5];
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive_src();
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    flushing = 1'b0;
    mwc = 16'd0;
    mpc = 16'd0;
    #1;
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'h0);
    chk_reset_vals("rst0");
    do_reset();

    // Empty FIFO, then one word: one cycle latency
    bus.out_ready = 1'b1;
    repeat (5) cycle();
    chk("empty_no_rd", 64'(rd_pulses), 64'd0);
    src_q.push_back(36'h0_0000_0042);
    cycle();
    #1;
    chk("lat1_valid", 64'(bus.out_valid), 64'h1);
    chk("lat1_data", 64'(bus.out_data), 64'h42);
    repeat (3) cycle();

    // Three-word packet streamed back to back
    do_reset();
    bus.out_ready = 1'b1;
    src_q.push_back(36'h0_0000_0001);
    src_q.push_back(36'h0_0000_0002);
    src_q.push_back(36'h8_0000_0003);
    repeat (6) cycle();
    chk("pkt3_n", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("pkt3_w0", 64'(got_q[0]), 64'h0_0000_0001);
      chk("pkt3_w1", 64'(got_q[1]), 64'h0_0000_0002);
      chk("pkt3_w2", 64'(got_q[2]), 64'h8_0000_0003);
    end
    chk("pkt3_wc", 64'(bus.word_count), 64'd3);
    chk("pkt3_pc", 64'(bus.pkt_count), 64'd1);

    // Back-pressure: buffer fills to two, then drains in order
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp5[i] = {(i == 4), 35'(32'h10 + i)};
      src_q.push_back(exp5[i]);
    end
    repeat (8) cycle();
    chk("bp_rd_pulses", 64'(rd_pulses), 64'd2);
    chk("bp_hold_data", 64'(bus.out_data), 64'h10);
    bus.out_ready = 1'b1;
    repeat (10) cycle();
    chk("bp_n", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("bp_w%0d", i), 64'(got_q[i]), 64'(exp5[i]));

    // Flush with a full buffer and a pending pop
    do_reset();
    bus.out_ready = 1'b0;
    src_q.push_back(36'h0_0000_0021);
    src_q.push_back(36'h0_0000_0022);
    src_q.push_back(36'h0_0000_000A);
    src_q.push_back(36'h8_0000_000B);
    src_q.push_back(36'h0_0000_000C);
    repeat (4) cycle();
    chk("fl_full", 64'(bus.out_valid), 64'h1);
    got_q.delete();
    busy_cnt = 0;
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    #1;
    chk("fl_busy", 64'(bus.flush_busy), 64'h1);
    chk("fl_wc", 64'(bus.word_count), 64'h0);
    repeat (6) cycle();
    chk("fl_busy_cycles", 64'(busy_cnt), 64'd2);
    chk("fl_n", 64'(got_q.size()), 64'd1);
    if (got_q.size() != 0)
      chk("fl_c", 64'(got_q[0]), 64'h0_0000_000C);
    chk("fl_wc_end", 64'(bus.word_count), 64'd1);

    // Reset mid-flush and with a full buffer
    do_reset();
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    repeat (2) cycle();
    chk("rf_wait", 64'(bus.flush_busy), 64'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk_reset_vals("rf");
    bus.out_ready = 1'b0;
    src_q.push_back(36'h0_1234_5678);
    src_q.push_back(36'h8_0ABC_DEF0);
    repeat (3) cycle();
    chk("rs_full", 64'(bus.out_valid), 64'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk_reset_vals("rs");

    // word_count wrap after 65536 handshakes
    do_reset();
    bus.out_ready = 1'b1;
    n = 0;
    while (mwc != 16'hFFFF && n < 70000) begin
      while (src_q.size() < 3) src_q.push_back(rnd_word());
      cycle();
      n++;
    end
    chk("wrap_reached", 64'(n < 70000), 64'h1);
    #1;
    chk("wrap_ffff", 64'(bus.word_count), 64'hFFFF);
    src_q.push_back(rnd_word());
    cycle();
    #1;
    chk("wrap_zero", 64'(bus.word_count), 64'h0);

    // Random traffic with flushes and occasional reset
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && src_q.size() < 8)
        src_q.push_back(rnd_word());
      bus.flush = ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 500) == 0);
      cycle();
    end
    rst = 1'b0;
    bus.flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
